// File: rtl/id_ex_skid_stage.sv
// Decode->execute boundary: two-entry skid buffer (M drives execute, S absorbs back-pressure)
// with load-use stall, writeback->decode bypass at capture, and writeback snooping of held entries.
module id_ex_skid_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 16,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pcplus4,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_memread,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pcplus4,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_memread,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              hazard_stall
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcplus4;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_entry;
    entry_t m_snoop, s_snoop;
    logic   wb_hit;
    logic   hazard;
    logic   accept;
    logic   drain;

    // Refresh operand data of a held entry when writeback targets one of its sources.
    function automatic entry_t snoop(input entry_t e, input logic hit,
                                     input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (hit && e.rs1 == rd) r.rs1_data = d;
        if (hit && e.rs2 == rd) r.rs2_data = d;
        return r;
    endfunction

    function automatic logic load_hit(input entry_t e,
                                      input logic u1, input logic [RA_W-1:0] r1,
                                      input logic u2, input logic [RA_W-1:0] r2);
        return e.valid && e.memread && (e.rd != '0) &&
               ((u1 && e.rd == r1) || (u2 && e.rd == r2));
    endfunction

    always_comb begin
        wb_hit = wb_en && (wb_rd != '0);

        in_entry          = '0;
        in_entry.valid    = 1'b1;
        in_entry.pc       = in_pc;
        in_entry.pcplus4  = in_pcplus4;
        in_entry.imm      = in_imm;
        in_entry.rs1      = in_rs1;
        in_entry.rs2      = in_rs2;
        in_entry.rd       = in_rd;
        in_entry.memread  = in_memread;
        in_entry.ctrl     = in_ctrl;
        in_entry.rs1_data = (wb_hit && wb_rd == in_rs1) ? wb_data : in_rs1_data;
        in_entry.rs2_data = (wb_hit && wb_rd == in_rs2) ? wb_data : in_rs2_data;

        hazard = in_valid &&
                 (load_hit(m_q, in_use_rs1, in_rs1, in_use_rs2, in_rs2) ||
                  load_hit(s_q, in_use_rs1, in_rs1, in_use_rs2, in_rs2));

        in_ready     = !rst && !s_q.valid && !hazard && !flush;
        hazard_stall = hazard && !s_q.valid && !flush;
        accept       = in_valid && in_ready;
        drain        = m_q.valid && out_ready;

        m_snoop = snoop(m_q, wb_hit, wb_rd, wb_data);
        s_snoop = snoop(s_q, wb_hit, wb_rd, wb_data);
        m_d     = m_snoop;
        s_d     = s_snoop;

        if (flush) begin
            // Data is left in place; only the valids die.
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (s_q.valid) begin
            if (drain) begin
                m_d       = s_snoop;
                s_d.valid = 1'b0;
            end
        end else if (accept) begin
            if (!m_q.valid || drain) m_d = in_entry;
            else                     s_d = in_entry;
        end else if (drain) begin
            m_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    // Bubbles must never carry control that could write architectural state.
    assign out_valid    = m_q.valid;
    assign out_ctrl     = m_q.valid ? m_q.ctrl : '0;
    assign out_memread  = m_q.valid & m_q.memread;
    assign out_pc       = m_q.pc;
    assign out_pcplus4  = m_q.pcplus4;
    assign out_imm      = m_q.imm;
    assign out_rs1_data = m_q.rs1_data;
    assign out_rs2_data = m_q.rs2_data;
    assign out_rd       = m_q.rd;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Randomized scoreboard bench: the model is an ordered queue of in-flight instructions
// (max two); the monitor compares and pops the head whenever execute takes one.
module tb_id_ex_skid_stage;

    localparam int XLEN = 64, CTRL_W = 16, RA_W = 5;

    logic clk = 0, rst, flush, in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_pcplus4, in_imm, in_rs1_data, in_rs2_data, wb_data;
    logic [RA_W-1:0] in_rs1, in_rs2, in_rd, wb_rd;
    logic in_use_rs1, in_use_rs2, in_memread, wb_en;
    logic [CTRL_W-1:0] in_ctrl;
    logic out_valid, out_ready, out_memread, hazard_stall;
    logic [XLEN-1:0] out_pc, out_pcplus4, out_imm, out_rs1_data, out_rs2_data;
    logic [RA_W-1:0] out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    id_ex_skid_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .in_rd(in_rd), .in_memread(in_memread), .in_ctrl(in_ctrl),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_imm(out_imm),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
        .out_memread(out_memread), .out_ctrl(out_ctrl), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]   pc, pcplus4, imm, d1, d2;
        logic [RA_W-1:0]   rs1, rs2, rd;
        logic              mr;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    ent_t mdl[$];
    int   n_vec = 0, n_bad = 0;
    bit   mon_en = 0;

    function automatic logic [XLEN-1:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit h = 0;
        foreach (mdl[i])
            if (mdl[i].mr && mdl[i].rd != 0 &&
                ((in_use_rs1 && mdl[i].rd == in_rs1) || (in_use_rs2 && mdl[i].rd == in_rs2)))
                h = 1;
        return in_valid && h;
    endfunction

    // Monitor: execute side of the handshake.
    always @(negedge clk) begin
        #2;
        if (mon_en && !rst) begin
            chk("out_valid", out_valid, mdl.size() != 0);
            if (mdl.size() != 0) begin
                chk("out_pc", out_pc, mdl[0].pc);
                chk("out_pcplus4", out_pcplus4, mdl[0].pcplus4);
                chk("out_imm", out_imm, mdl[0].imm);
                chk("out_rs1_data", out_rs1_data, mdl[0].d1);
                chk("out_rs2_data", out_rs2_data, mdl[0].d2);
                chk("out_rd", out_rd, mdl[0].rd);
                chk("out_memread", out_memread, mdl[0].mr);
                chk("out_ctrl", out_ctrl, mdl[0].ctrl);
                if (out_ready) void'(mdl.pop_front());
            end else begin
                chk("bubble_ctrl", out_ctrl, 0);
                chk("bubble_memread", out_memread, 0);
            end
        end
    end

    initial begin
        bit   exp_rdy, exp_stall;
        ent_t e;
        // Reset with every input driven high.
        rst = 1; flush = 1; in_valid = 1; out_ready = 1; wb_en = 1;
        in_pc = '1; in_pcplus4 = '1; in_imm = '1; in_rs1_data = '1; in_rs2_data = '1; wb_data = '1;
        in_rs1 = '1; in_rs2 = '1; in_rd = '1; wb_rd = '1;
        in_use_rs1 = 1; in_use_rs2 = 1; in_memread = 1; in_ctrl = '1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rs1_data", out_rs1_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_memread", out_memread, 0);
        chk("rst_hazard_stall", hazard_stall, 0);
        mon_en = 1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            rst         = (cyc >= 1500 && cyc < 1502);
            flush       = ($urandom_range(0, 99) < 5);
            in_valid    = ($urandom_range(0, 99) < 75);
            out_ready   = (cyc % 200 < 20) ? 1'b0 : ($urandom_range(0, 99) < 60);
            in_pc       = r64(); in_pcplus4 = in_pc + 4; in_imm = r64();
            in_rs1_data = r64(); in_rs2_data = r64(); wb_data = r64();
            in_rs1      = RA_W'($urandom_range(0, 7));
            in_rs2      = RA_W'($urandom_range(0, 7));
            in_rd       = RA_W'($urandom_range(0, 7));
            wb_rd       = RA_W'($urandom_range(0, 7));
            in_use_rs1  = $urandom_range(0, 3) != 0;
            in_use_rs2  = $urandom_range(0, 1) != 0;
            in_memread  = $urandom_range(0, 2) == 0;
            wb_en       = $urandom_range(0, 1) != 0;
            in_ctrl     = CTRL_W'($urandom);
            if (cyc == 0) begin
                flush = 0; in_valid = 1; in_pc = 64'h100; in_pcplus4 = 64'h104;
            end
            #1;
            exp_rdy   = !rst && mdl.size() < 2 && !model_hazard() && !flush;
            exp_stall = model_hazard() && mdl.size() < 2 && !flush;
            chk("in_ready", in_ready, exp_rdy);
            if (!rst) chk("hazard_stall", hazard_stall, exp_stall);

            @(posedge clk);
            // Monitor already removed the head if it was handed off this cycle.
            if (rst) mdl.delete();
            else begin
                if (wb_en && wb_rd != 0)
                    foreach (mdl[i]) begin
                        if (mdl[i].rs1 == wb_rd) mdl[i].d1 = wb_data;
                        if (mdl[i].rs2 == wb_rd) mdl[i].d2 = wb_data;
                    end
                if (flush) mdl.delete();
                else if (in_valid && exp_rdy) begin
                    e.pc = in_pc; e.pcplus4 = in_pcplus4; e.imm = in_imm;
                    e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
                    e.mr = in_memread; e.ctrl = in_ctrl;
                    e.d1 = (wb_en && wb_rd != 0 && wb_rd == in_rs1) ? wb_data : in_rs1_data;
                    e.d2 = (wb_en && wb_rd != 0 && wb_rd == in_rs2) ? wb_data : in_rs2_data;
                    mdl.push_back(e);
                end
            end
        end
        @(negedge clk); #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
